// File: rtl/video_rx_pkg.sv
// video_rx_pkg
// Shared types and helpers for the video timing receiver:
//   rx_state_t  - lock-tracking state machine encoding
//   CRC_POLY    - CRC-16-CCITT polynomial
//   CRC_INIT    - CRC seed applied at every frame boundary
//   crc16_step  - folds one 16-bit pixel into a running CRC, MSB first
package video_rx_pkg;

    typedef enum logic [1:0] {
        IDLE,
        MEASURE,
        VERIFY,
        LOCKED
    } rx_state_t;

    localparam logic [15:0] CRC_POLY = 16'h1021;
    localparam logic [15:0] CRC_INIT = 16'hFFFF;

    function automatic logic [15:0] crc16_step(input logic [15:0] crc,
                                               input logic [15:0] data16);
        logic [15:0] c;
        c = crc;
        for (int unsigned i = 0; i < 16; i++) begin
            if (c[15] ^ data16[4'(15 - i)])
                c = {c[14:0], 1'b0} ^ CRC_POLY;
            else
                c = {c[14:0], 1'b0};
        end
        return c;
    endfunction

endpackage

// File: rtl/video_crc16.sv
// video_crc16
// Running CRC-16-CCITT over the active pixels of one frame.
// Ports:
//   pixel_clk  in   pixel clock
//   sys_rst_n  in   asynchronous active-low reset
//   clear      in   frame boundary: restart from CRC_INIT
//   en         in   pixel present this clock
//   data       in   16-bit pixel
//   crc        out  CRC of the pixels seen since the last clear
module video_crc16
    import video_rx_pkg::*;
(
    input  logic        pixel_clk,
    input  logic        sys_rst_n,
    input  logic        clear,
    input  logic        en,
    input  logic [15:0] data,
    output logic [15:0] crc
);

    always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
        if (!sys_rst_n)
            crc <= CRC_INIT;
        else if (clear)
            // A pixel coinciding with the boundary belongs to the new frame.
            crc <= en ? crc16_step(CRC_INIT, data) : CRC_INIT;
        else if (en)
            crc <= crc16_step(crc, data);
    end

endmodule

// File: rtl/video_timing_rx.sv
// video_timing_rx
// Receives a parallel RGB565 stream, recovers pixel x/y, measures
// h_total/h_active/v_total/v_active and declares lock after LOCK_FRAMES
// consecutive identical frames.
// Build option: FRAME_CRC_EN adds a per-frame CRC-16-CCITT on frame_crc;
// without it frame_crc is tied to zero.
// Ports:
//   pixel_clk, sys_rst_n               clock, async active-low reset
//   video_hs/vs/de/rgb                 input stream
//   pixel_valid/data/x/y               pixel outputs, 2 clocks behind inputs
//   frame_start, line_start            pulses with pixel (0,0) / every x=0
//   h_total/h_active/v_total/v_active  last published frame measurements
//   locked, timing_err                 lock status, error pulse
//   frame_crc                          CRC of previous frame's active pixels
module video_timing_rx
    import video_rx_pkg::*;
#(
    parameter int unsigned CNT_W        = 12,
    parameter int unsigned LOCK_FRAMES  = 2,
    parameter int unsigned SYNC_ACT_LOW = 1
) (
    input  logic             pixel_clk,
    input  logic             sys_rst_n,
    input  logic             video_hs,
    input  logic             video_vs,
    input  logic             video_de,
    input  logic [15:0]      video_rgb,
    output logic             pixel_valid,
    output logic [15:0]      pixel_data,
    output logic [CNT_W-1:0] pixel_x,
    output logic [CNT_W-1:0] pixel_y,
    output logic             frame_start,
    output logic             line_start,
    output logic [CNT_W-1:0] h_total,
    output logic [CNT_W-1:0] h_active,
    output logic [CNT_W-1:0] v_total,
    output logic [CNT_W-1:0] v_active,
    output logic             locked,
    output logic             timing_err,
    output logic [15:0]      frame_crc
);

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic             SYNC_INV = (SYNC_ACT_LOW != 0);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

    // Sync inputs are stored as "asserted" levels so edge logic is polarity-free.
    logic              hs_r, vs_r, de_r, hs_d, vs_d, de_d;
    logic [15:0]       rgb_r;
    logic              hs_edge, vs_edge, de_rise, de_fall;
    rx_state_t         state;
    logic [3:0]        match_cnt, match_inc;
    logic [CNT_W-1:0]  h_cnt, de_cnt, h_last, v_cnt, va_cnt, ref_de;
    logic              has_ref, bad;
    logic [CNT_W-1:0]  h_cnt_n, de_cnt_n, ht_fin, v_fin, va_fin, ref_fin;
    logic              line_act, bad_fin, sat, frame_ok;

    assign hs_edge   = hs_r & ~hs_d;
    assign vs_edge   = vs_r & ~vs_d;
    assign de_rise   = de_r & ~de_d;
    assign de_fall   = ~de_r & de_d;
    assign match_inc = match_cnt + 4'd1;

    // "_fin" values fold in the line closing this clock, so a coincident
    // hs/vs edge closes the line before the frame.
    always_comb begin
        h_cnt_n  = hs_edge ? CNT_W'(1) : sat_inc(h_cnt);
        de_cnt_n = hs_edge ? CNT_W'(de_r) : (de_r ? sat_inc(de_cnt) : de_cnt);
        line_act = hs_edge && (de_cnt != '0);
        ht_fin   = hs_edge ? h_cnt : h_last;
        v_fin    = hs_edge ? sat_inc(v_cnt) : v_cnt;
        va_fin   = line_act ? sat_inc(va_cnt) : va_cnt;
        ref_fin  = (line_act && !has_ref) ? de_cnt : ref_de;
        bad_fin  = bad || (line_act && has_ref && (de_cnt != ref_de));
        sat      = ((h_cnt_n  == CNT_MAX) && (h_cnt  != CNT_MAX)) ||
                   ((de_cnt_n == CNT_MAX) && (de_cnt != CNT_MAX)) ||
                   ((v_fin    == CNT_MAX) && (v_cnt  != CNT_MAX)) ||
                   ((va_fin   == CNT_MAX) && (va_cnt != CNT_MAX));
        frame_ok = !bad_fin && (ht_fin == h_total) && (ref_fin == h_active) &&
                   (v_fin == v_total) && (va_fin == v_active);
    end

`ifdef FRAME_CRC_EN
    logic [15:0] crc_cur;

    video_crc16 u_crc (
        .pixel_clk (pixel_clk),
        .sys_rst_n (sys_rst_n),
        .clear     (vs_edge),
        .en        (de_r),
        .data      (rgb_r),
        .crc       (crc_cur)
    );
`else
    assign frame_crc = '0;
`endif

    always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            {hs_r, vs_r, de_r, hs_d, vs_d, de_d} <= '0;
            rgb_r       <= '0;
            pixel_valid <= 1'b0;
            pixel_data  <= '0;
            pixel_x     <= '0;
            pixel_y     <= '0;
            frame_start <= 1'b0;
            line_start  <= 1'b0;
            h_total     <= '0;
            h_active    <= '0;
            v_total     <= '0;
            v_active    <= '0;
            locked      <= 1'b0;
            timing_err  <= 1'b0;
            state       <= IDLE;
            match_cnt   <= '0;
            h_cnt       <= '0;
            de_cnt      <= '0;
            h_last      <= '0;
            v_cnt       <= '0;
            va_cnt      <= '0;
            ref_de      <= '0;
            has_ref     <= 1'b0;
            bad         <= 1'b0;
`ifdef FRAME_CRC_EN
            frame_crc   <= '0;
`endif
        end else begin
            hs_r  <= video_hs ^ SYNC_INV;
            vs_r  <= video_vs ^ SYNC_INV;
            de_r  <= video_de;
            rgb_r <= video_rgb;
            hs_d  <= hs_r;
            vs_d  <= vs_r;
            de_d  <= de_r;

            pixel_valid <= de_r;
            pixel_data  <= de_r ? rgb_r : '0;
            if (de_r)
                pixel_x <= de_d ? sat_inc(pixel_x) : '0;
            if (vs_edge)
                pixel_y <= '0;
            else if (de_fall)
                pixel_y <= sat_inc(pixel_y);
            line_start  <= de_rise && (state != IDLE);
            frame_start <= de_rise && (state != IDLE) && (vs_edge || (pixel_y == '0));

            h_cnt  <= h_cnt_n;
            de_cnt <= de_cnt_n;
            if (hs_edge)
                h_last <= h_cnt;
            if (vs_edge) begin
                v_cnt   <= '0;
                va_cnt  <= '0;
                ref_de  <= '0;
                has_ref <= 1'b0;
                bad     <= 1'b0;
            end else begin
                v_cnt   <= v_fin;
                va_cnt  <= va_fin;
                ref_de  <= ref_fin;
                has_ref <= has_ref | line_act;
                bad     <= bad_fin;
            end

            timing_err <= 1'b0;
            if (sat) begin
                state      <= IDLE;
                locked     <= 1'b0;
                timing_err <= 1'b1;
                match_cnt  <= '0;
            end else if (vs_edge) begin
                // Every non-IDLE boundary republishes; on a match the values are unchanged.
                if (state != IDLE) begin
                    h_total  <= ht_fin;
                    h_active <= ref_fin;
                    v_total  <= v_fin;
                    v_active <= va_fin;
`ifdef FRAME_CRC_EN
                    frame_crc <= crc_cur;
`endif
                end
                case (state)
                    IDLE: state <= MEASURE;
                    MEASURE: begin
                        state     <= VERIFY;
                        match_cnt <= '0;
                    end
                    VERIFY: begin
                        if (frame_ok) begin
                            match_cnt <= match_inc;
                            if (match_inc == 4'(LOCK_FRAMES)) begin
                                state  <= LOCKED;
                                locked <= 1'b1;
                            end
                        end else begin
                            match_cnt <= '0;
                        end
                    end
                    LOCKED: begin
                        if (!frame_ok) begin
                            state      <= VERIFY;
                            locked     <= 1'b0;
                            timing_err <= 1'b1;
                            match_cnt  <= '0;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_video_timing_rx.sv
// Directed bench for video_timing_rx. A small raster (28 clocks x 14 lines,
// active 16x8, active-low syncs) replaces 1024x768 so the run stays short;
// the sync, latency and boundary relationships are the same. The vs sync is
// placed at lines 12-13 so each generated frame ends with its own boundary.
module tb_video_timing_rx;

    localparam int HS = 4, HBP = 4, HACT = 16, HTOT = 28;

    logic        pixel_clk = 1'b0;
    logic        sys_rst_n;
    logic        video_hs, video_vs, video_de;
    logic [15:0] video_rgb;
    logic        pixel_valid, frame_start, line_start, locked, timing_err;
    logic [15:0] pixel_data, frame_crc;
    logic [11:0] pixel_x, pixel_y, h_total, h_active, v_total, v_active;

    always #5 pixel_clk = ~pixel_clk;

    video_timing_rx #(.CNT_W(12), .LOCK_FRAMES(2), .SYNC_ACT_LOW(1)) dut (
        .pixel_clk(pixel_clk), .sys_rst_n(sys_rst_n),
        .video_hs(video_hs), .video_vs(video_vs), .video_de(video_de), .video_rgb(video_rgb),
        .pixel_valid(pixel_valid), .pixel_data(pixel_data), .pixel_x(pixel_x), .pixel_y(pixel_y),
        .frame_start(frame_start), .line_start(line_start),
        .h_total(h_total), .h_active(h_active), .v_total(v_total), .v_active(v_active),
        .locked(locked), .timing_err(timing_err), .frame_crc(frame_crc)
    );

    int n_checks = 0, n_fail = 0;
    int cyc = 0, te_count = 0;
    always @(posedge pixel_clk) cyc++;
    always @(negedge pixel_clk) if (timing_err === 1'b1) te_count++;

    // pixel monitor
    logic        mon_en = 1'b0, first_de_pending = 1'b0, fs_xy_ok;
    int          fs_cnt, ls_cnt, px_bad, fs_cyc, first_de_cyc;
    logic [11:0] last_x, last_y;
    always @(negedge pixel_clk) begin
        if (mon_en) begin
            if (pixel_valid && (pixel_data[10:0] != pixel_x[10:0])) px_bad++;
            if (!pixel_valid && (pixel_data != 16'h0)) px_bad++;
            if (line_start) ls_cnt++;
            if (frame_start) begin
                fs_cnt++;
                fs_cyc   = cyc;
                fs_xy_ok = pixel_valid && (pixel_x == 12'd0) && (pixel_y == 12'd0);
            end
            if (pixel_valid) begin
                last_x = pixel_x;
                last_y = pixel_y;
            end
        end
    end

    // boundary snapshot
    logic [11:0] s_ht, s_ha, s_vt, s_va;
    logic        s_lk;
    logic [15:0] s_crc, model_crc;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [15:0] bench_crc(input logic [15:0] c, input logic [15:0] d);
        logic [15:0] r;
        r = c;
        for (int b = 15; b >= 0; b--)
            r = (r[15] ^ d[b]) ? ({r[14:0], 1'b0} ^ 16'h1021) : {r[14:0], 1'b0};
        return r;
    endfunction

    task automatic mon_reset();
        fs_cnt = 0; ls_cnt = 0; px_bad = 0; fs_cyc = 0; first_de_cyc = 0;
        fs_xy_ok = 1'b0; last_x = '0; last_y = '0;
        first_de_pending = 1'b1;
        mon_en = 1'b1;
    endtask

    task automatic drive(input logic hs_a, input logic vs_a, input logic de, input logic [15:0] d);
        @(negedge pixel_clk);
        video_hs  = ~hs_a;
        video_vs  = ~vs_a;
        video_de  = de;
        video_rgb = de ? d : 16'h0;
    endtask

    task automatic drive_line(input int htot, input logic vs_a, input logic active,
                              input int de_w, input logic snap);
        logic de;
        int   x;
        for (int c = 0; c < htot; c++) begin
            x  = c - (HS + HBP);
            de = active && (x >= 0) && (x < de_w);
            drive(c < HS, vs_a, de, 16'(x));
            if (de) begin
                model_crc = bench_crc(model_crc, 16'(x));
                if (first_de_pending) begin
                    first_de_cyc = cyc;
                    first_de_pending = 1'b0;
                end
            end
            if (snap && c == 5) begin
                s_ht = h_total; s_ha = h_active; s_vt = v_total; s_va = v_active;
                s_lk = locked;  s_crc = frame_crc;
            end
        end
    endtask

    // Lines 0-1 back porch, 2-9 active, 10-11 front porch, 12-13 vs sync.
    task automatic gen_frame(input int htot, input int bad_line);
        model_crc = 16'hFFFF;
        for (int l = 0; l < 14; l++)
            drive_line(htot, l >= 12, (l >= 2) && (l < 10),
                       (l == bad_line) ? HACT - 1 : HACT, l == 12);
    endtask

    typedef struct {
        int   htot;
        int   bad_line;
        int   ht, ha, vt, va;
        logic lk;
        int   te;
    } frame_vec_t;

    frame_vec_t tbl[12];
    int te0;

    initial begin
        // stimulus of each frame, then measurements/lock/error pulses at its closing boundary
        tbl[0]  = '{28, -1,  0,  0,  0, 0, 1'b0, 0};  // first vs edge: IDLE -> MEASURE
        tbl[1]  = '{28, -1, 28, 16, 14, 8, 1'b0, 0};  // first publish
        tbl[2]  = '{28, -1, 28, 16, 14, 8, 1'b0, 0};
        tbl[3]  = '{28, -1, 28, 16, 14, 8, 1'b1, 0};  // 4th vs edge locks
        tbl[4]  = '{28, -1, 28, 16, 14, 8, 1'b1, 0};
        tbl[5]  = '{29, -1, 29, 16, 14, 8, 1'b0, 1};  // longer lines break lock
        tbl[6]  = '{28, -1, 28, 16, 14, 8, 1'b0, 0};  // republish, no pulse in VERIFY
        tbl[7]  = '{28, -1, 28, 16, 14, 8, 1'b0, 0};
        tbl[8]  = '{28, -1, 28, 16, 14, 8, 1'b1, 0};  // relocked
        tbl[9]  = '{28, -1, 28, 16, 14, 8, 1'b1, 0};
        tbl[10] = '{28,  5, 28, 16, 14, 8, 1'b0, 1};  // one short de line: bad frame
        tbl[11] = '{28, -1, 28, 16, 14, 8, 1'b0, 0};

        sys_rst_n = 1'b0;
        video_hs = 1'b1; video_vs = 1'b1; video_de = 1'b0; video_rgb = 16'h0;
        repeat (3) @(negedge pixel_clk);
        check("reset pixel outs", {pixel_valid, pixel_data, pixel_x, pixel_y, frame_start, line_start}, 64'd0);
        check("reset measurements", {h_total, h_active, v_total, v_active}, 64'd0);
        check("reset status", {locked, timing_err, frame_crc}, 64'd0);
        sys_rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            if (i == 2) mon_reset();
            te0 = te_count;
            gen_frame(tbl[i].htot, tbl[i].bad_line);
            mon_en = 1'b0;
            check($sformatf("f%0d h_total", i),  s_ht, tbl[i].ht);
            check($sformatf("f%0d h_active", i), s_ha, tbl[i].ha);
            check($sformatf("f%0d v_total", i),  s_vt, tbl[i].vt);
            check($sformatf("f%0d v_active", i), s_va, tbl[i].va);
            check($sformatf("f%0d locked", i),   s_lk, tbl[i].lk);
            check($sformatf("f%0d timing_err pulses", i), te_count - te0, tbl[i].te);
`ifdef FRAME_CRC_EN
            if (i > 0) check($sformatf("f%0d frame_crc", i), s_crc, model_crc);
`endif
            if (i == 2) begin
                check("frame_start count", fs_cnt, 1);
                check("frame_start latency", fs_cyc - first_de_cyc, 2);
                check("frame_start at 0,0", fs_xy_ok, 1);
                check("line_start count", ls_cnt, 8);
                check("last pixel x", last_x, 15);
                check("last pixel y", last_y, 7);
                check("pixel data vs x", px_bad, 0);
            end
        end

        // relock, then run 4100 lines with no vs: v counter saturates
        gen_frame(HTOT, -1);
        check("relock before saturation", s_lk, 1'b1);
        te0 = te_count;
        for (int l = 0; l < 4100; l++) drive_line(8, 1'b0, 1'b0, 0, 1'b0);
        check("saturation timing_err pulses", te_count - te0, 1);
        check("saturation locked", locked, 1'b0);
        te0 = te_count;
        gen_frame(HTOT, -1);  // back in IDLE: this boundary must not publish
        check("post-saturation v_total held", s_vt, 14);
        check("post-saturation locked", s_lk, 1'b0);
        check("post-saturation no pulse", te_count - te0, 0);

        // reset in the middle of an active line
        for (int c = 0; c < 12; c++) drive(c < HS, 1'b0, c >= HS + HBP, 16'(c));
        @(negedge pixel_clk);
        sys_rst_n = 1'b0;
        #1;
        check("midline reset pixel outs", {pixel_valid, pixel_data, pixel_x, pixel_y, frame_start, line_start}, 64'd0);
        check("midline reset measurements", {h_total, h_active, v_total, v_active}, 64'd0);
        check("midline reset status", {locked, timing_err, frame_crc}, 64'd0);
        video_hs = 1'b1; video_vs = 1'b1; video_de = 1'b0; video_rgb = 16'h0;
        repeat (2) @(negedge pixel_clk);
        sys_rst_n = 1'b1;
        mon_reset();
        gen_frame(HTOT, -1);
        mon_en = 1'b0;
        check("post-reset frame_start before vs", fs_cnt, 0);
        check("post-reset line_start before vs", ls_cnt, 0);
        check("post-reset first boundary h_total", s_ht, 0);
        mon_reset();
        gen_frame(HTOT, -1);
        mon_en = 1'b0;
        check("post-reset frame_start after vs", fs_cnt, 1);
        check("post-reset second boundary h_total", s_ht, 28);
        check("post-reset second boundary v_active", s_va, 8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
